// File: rtl/collision_scanner.sv
// Frame-triggered collision scanner: checks each probe position against one segment
// slot per clock and reports sticky per-probe hits with the first-hit segment index.
module collision_scanner #(
    parameter int NUM_SEGMENTS = 7,
    parameter int NUM_PROBES   = 3,
    parameter int POS_W        = 8,
    parameter int IDX_W        = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_PROBES*POS_W-1:0]   probe_pos,
    input  logic [NUM_PROBES-1:0]         probe_en,
    input  logic [NUM_SEGMENTS*POS_W-1:0] segment_pos,
    input  logic [NUM_SEGMENTS-1:0]       segment_active,
    input  logic                          early_exit,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_PROBES-1:0]         collision,
    output logic [NUM_PROBES*IDX_W-1:0]   hit_index
);

    localparam logic [IDX_W-1:0] NO_HIT   = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NUM_SEGMENTS - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t                          state_q;
    logic [IDX_W-1:0]                cnt_q;
    logic                            busy_q;
    logic                            done_q;
    logic [NUM_PROBES-1:0]           collision_q;
    logic [NUM_PROBES*IDX_W-1:0]     hitIndex_q;
    logic [NUM_PROBES*POS_W-1:0]     snapProbe_q;
    logic [NUM_PROBES-1:0]           snapEn_q;
    logic [NUM_SEGMENTS*POS_W-1:0]   snapSeg_q;
    logic [NUM_SEGMENTS-1:0]         snapActive_q;
    logic                            snapEarly_q;

    logic [POS_W-1:0]                curSeg;
    logic                            curActive;
    logic [NUM_PROBES-1:0]           hit;
    logic [NUM_PROBES-1:0]           collision_d;
    logic [NUM_PROBES*IDX_W-1:0]     hitIndex_d;
    logic                            lastSeg;
    logic                            allHit;

    // Select the segment under the counter and compare every probe against it in parallel.
    always_comb begin
        curSeg    = '0;
        curActive = 1'b0;
        for (int k = 0; k < NUM_SEGMENTS; k++) begin
            if (cnt_q == IDX_W'(k)) begin
                curSeg    = snapSeg_q[k*POS_W +: POS_W];
                curActive = snapActive_q[k];
            end
        end

        hit        = '0;
        hitIndex_d = hitIndex_q;
        for (int p = 0; p < NUM_PROBES; p++) begin
            hit[p] = curActive && snapEn_q[p] &&
                     (snapProbe_q[p*POS_W +: POS_W] == curSeg);
            if (hit[p] && !collision_q[p]) begin
                hitIndex_d[p*IDX_W +: IDX_W] = cnt_q;
            end
        end
        collision_d = collision_q | hit;

        lastSeg = (cnt_q == LAST_SEG);
        // Early exit needs at least one enabled probe, otherwise an empty mask would match trivially.
        allHit  = snapEarly_q && (|snapEn_q) &&
                  ((collision_d & snapEn_q) == snapEn_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            collision_q  <= '0;
            hitIndex_q   <= {NUM_PROBES{NO_HIT}};
            snapProbe_q  <= '0;
            snapEn_q     <= '0;
            snapSeg_q    <= '0;
            snapActive_q <= '0;
            snapEarly_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snapProbe_q  <= probe_pos;
                        snapEn_q     <= probe_en;
                        snapSeg_q    <= segment_pos;
                        snapActive_q <= segment_active;
                        snapEarly_q  <= early_exit;
                        collision_q  <= '0;
                        hitIndex_q   <= {NUM_PROBES{NO_HIT}};
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= SCAN;
                    end
                end
                SCAN: begin
                    collision_q <= collision_d;
                    hitIndex_q  <= hitIndex_d;
                    if (lastSeg || allHit) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = collision_q;
    assign hit_index = hitIndex_q;

endmodule
